// File: rtl/histogram_hesaplama_if.sv
// Pixel input stream and histogram output stream of histogram_hesaplama.
// Both streams use the same handshake: a transfer happens on a rising clock
// edge where valid && ready are both high; once valid is raised it stays high
// and its payload stays stable until that transfer happens.
interface histogram_hesaplama_if #(
    parameter int BIN_W = 24
);
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       pix_data;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_bin;
    logic [BIN_W-1:0] hist_count;
    logic             hist_last;
    logic             frame_done;
    logic [1:0]       dbg_state;

    // Pixel producer / histogram consumer side
    modport master (
        output pix_valid, pix_data, hist_ready,
        input  pix_ready, hist_valid, hist_bin, hist_count, hist_last,
               frame_done, dbg_state
    );

    // Histogram block side
    modport slave (
        input  pix_valid, pix_data, hist_ready,
        output pix_ready, hist_valid, hist_bin, hist_count, hist_last,
               frame_done, dbg_state
    );
endinterface

// File: rtl/histogram_hesaplama.sv
// Streaming 256-bin histogram of 8-bit pixels over a frame of PIXELS pixels.
// Bins are built with a read-modify-write pipeline (S1 read, S2 count+1,
// write from S2) with forwarding, then streamed out in order 0..255; each bin
// is zeroed as it is read so the next frame starts from a clean table.
module histogram_hesaplama #(
    parameter int PIXELS = 76800,
    parameter int BIN_W  = 24
) (
    input logic                  clk,
    input logic                  rst_n,
    histogram_hesaplama_if.slave bus
);
    localparam int               CNT_W    = $clog2(PIXELS + 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0] PIX_ALL  = CNT_W'(PIXELS);
    localparam logic [BIN_W-1:0] BIN_MAX  = '1;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t state, state_nx;

    // Bin memory, not reset; CLEAR initialises it after every reset
    logic [BIN_W-1:0] mem [256];
    logic [BIN_W-1:0] rd_data;
    logic [7:0]       rd_addr;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [BIN_W-1:0] wr_data;

    // idx walks the bins in CLEAR and READOUT
    logic [7:0]       idx;
    logic [CNT_W-1:0] pix_cnt;
    logic             frame_done_q;

    // Increment pipeline: S1 (read issued), S2 (count+1, writes next edge),
    // W (the write that just landed; memory read on that edge saw old data)
    logic             s1_valid;
    logic [7:0]       s1_bin;
    logic             s2_valid;
    logic [7:0]       s2_bin;
    logic [BIN_W-1:0] s2_count;
    logic             w_valid;
    logic [7:0]       w_bin;
    logic [BIN_W-1:0] w_count;
    logic [BIN_W-1:0] fwd_count;
    logic [BIN_W-1:0] inc_count;

    logic accept;
    logic hist_hs;
    logic last_hs;

    assign bus.pix_ready  = (state == COLLECT) && (pix_cnt < PIX_ALL);
    assign accept         = bus.pix_valid && bus.pix_ready;
    assign hist_hs        = (state == READOUT) && bus.hist_ready;
    assign last_hs        = hist_hs && (idx == 8'hFF);

    assign bus.hist_valid = (state == READOUT);
    assign bus.hist_bin   = (state == READOUT) ? idx : 8'd0;
    assign bus.hist_count = (state == READOUT) ? rd_data : '0;
    assign bus.hist_last  = (state == READOUT) && (idx == 8'hFF);
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nx;
    end

    // Next state and memory port steering
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_addr  = s2_bin;
        wr_data  = s2_count;
        rd_addr  = bus.pix_data;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = idx;
                wr_data = '0;
                if (idx == 8'hFF) state_nx = COLLECT;
            end
            COLLECT: begin
                wr_en = s2_valid;
                if (accept && (pix_cnt == PIX_LAST)) state_nx = DRAIN;
            end
            DRAIN: begin
                wr_en   = s2_valid;
                // bin 0 is fetched on the exit edge, after the last write landed
                rd_addr = 8'd0;
                if (!s1_valid && !s2_valid) state_nx = READOUT;
            end
            READOUT: begin
                wr_en   = hist_hs;
                wr_addr = idx;
                wr_data = '0;
                // prefetch the next bin on a handshake, otherwise re-read the
                // presented one so the output holds while stalled
                rd_addr = hist_hs ? (idx + 8'd1) : idx;
                if (last_hs) state_nx = COLLECT;
            end
            default: state_nx = CLEAR;
        endcase
    end

    // Single write port and registered read of the bin memory
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // Bin index, pixel counter and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 8'd0;
            pix_cnt      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if ((state == CLEAR) || hist_hs) idx <= idx + 8'd1;
            if (accept)       pix_cnt <= pix_cnt + CNT_W'(1);
            else if (last_hs) pix_cnt <= '0;
            frame_done_q <= last_hs;
        end
    end

    // Newest matching in-flight value wins over the memory read data
    always_comb begin
        fwd_count = rd_data;
        if (w_valid && (w_bin == s1_bin))   fwd_count = w_count;
        if (s2_valid && (s2_bin == s1_bin)) fwd_count = s2_count;
        inc_count = (fwd_count == BIN_MAX) ? fwd_count : fwd_count + BIN_W'(1);
    end

    // Increment pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_bin   <= 8'd0;
            s2_valid <= 1'b0;
            s2_bin   <= 8'd0;
            s2_count <= '0;
            w_valid  <= 1'b0;
            w_bin    <= 8'd0;
            w_count  <= '0;
        end else begin
            s1_valid <= accept;
            s1_bin   <= bus.pix_data;
            s2_valid <= s1_valid;
            s2_bin   <= s1_bin;
            s2_count <= inc_count;
            w_valid  <= s2_valid;
            w_bin    <= s2_bin;
            w_count  <= s2_count;
        end
    end
endmodule

// File: tb/tb_histogram_hesaplama.sv
// Directed bench for histogram_hesaplama. Three instances cover the different
// PIXELS / BIN_W settings; sel routes the shared stimulus and observation to
// one of them at a time.
module tb_histogram_hesaplama;
    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       pv;
    logic [7:0] pd;
    logic       hr;

    histogram_hesaplama_if #(.BIN_W(24)) if_a ();
    histogram_hesaplama_if #(.BIN_W(24)) if_b ();
    histogram_hesaplama_if #(.BIN_W(4))  if_c ();

    histogram_hesaplama #(.PIXELS(16),  .BIN_W(24)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    histogram_hesaplama #(.PIXELS(256), .BIN_W(24)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    histogram_hesaplama #(.PIXELS(20),  .BIN_W(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.pix_valid  = pv && (sel == 2'd0);
    assign if_b.pix_valid  = pv && (sel == 2'd1);
    assign if_c.pix_valid  = pv && (sel == 2'd2);
    assign if_a.pix_data   = pd;
    assign if_b.pix_data   = pd;
    assign if_c.pix_data   = pd;
    assign if_a.hist_ready = hr && (sel == 2'd0);
    assign if_b.hist_ready = hr && (sel == 2'd1);
    assign if_c.hist_ready = hr && (sel == 2'd2);

    logic        o_pix_ready;
    logic        o_hist_valid;
    logic [7:0]  o_hist_bin;
    logic [31:0] o_hist_count;
    logic        o_hist_last;
    logic        o_frame_done;

    // Observation mux for the selected instance
    always_comb begin
        o_pix_ready  = if_a.pix_ready;
        o_hist_valid = if_a.hist_valid;
        o_hist_bin   = if_a.hist_bin;
        o_hist_count = {8'd0, if_a.hist_count};
        o_hist_last  = if_a.hist_last;
        o_frame_done = if_a.frame_done;
        if (sel == 2'd1) begin
            o_pix_ready  = if_b.pix_ready;
            o_hist_valid = if_b.hist_valid;
            o_hist_bin   = if_b.hist_bin;
            o_hist_count = {8'd0, if_b.hist_count};
            o_hist_last  = if_b.hist_last;
            o_frame_done = if_b.frame_done;
        end else if (sel == 2'd2) begin
            o_pix_ready  = if_c.pix_ready;
            o_hist_valid = if_c.hist_valid;
            o_hist_bin   = if_c.hist_bin;
            o_hist_count = {28'd0, if_c.hist_count};
            o_hist_last  = if_c.hist_last;
            o_frame_done = if_c.frame_done;
        end
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_h [256];
    logic [31:0] exp_q [$];
    logic [31:0] got [256];

    // Readout results
    int   lat;
    int   order_err;
    int   last_err;
    int   hold_err;
    int   fd_early;
    int   bad;
    logic timeout;
    logic first_ready;
    logic fd1;
    logic pr1;
    logic fd2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_add(input logic [7:0] v, input logic [31:0] maxv);
        if (exp_h[v] < maxv) exp_h[v] = exp_h[v] + 32'd1;
    endtask

    task automatic model_push();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(exp_h[i]);
            exp_h[i] = 32'd0;
        end
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!o_pix_ready && n < 400);
    endtask

    task automatic send_pixel(input logic [7:0] v);
        int   budget;
        logic ok;
        pv = 1'b1;
        pd = v;
        budget = 0;
        ok = 1'b0;
        while (!ok && budget < 100) begin
            @(negedge clk);
            ok = o_pix_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        pv = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic readout(input bit rand_ready);
        int          k;
        int          cyc;
        logic        s_valid;
        logic        s_last;
        logic [7:0]  s_bin;
        logic [31:0] s_count;
        logic        prev_stall;
        logic        p_last;
        logic [7:0]  p_bin;
        logic [31:0] p_count;
        logic [31:0] e;
        k = 0; cyc = 0; lat = 0; timeout = 1'b0; first_ready = 1'b0;
        order_err = 0; last_err = 0; hold_err = 0; fd_early = 0; bad = 0;
        prev_stall = 1'b0; p_last = 1'b0; p_bin = 8'd0; p_count = 32'd0;
        while (k < 256 && !timeout) begin
            hr = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_ready = o_pix_ready;
            s_valid = o_hist_valid;
            s_bin   = o_hist_bin;
            s_count = o_hist_count;
            s_last  = o_hist_last;
            if (o_frame_done) fd_early++;
            if (s_valid && lat == 0) lat = cyc;
            if (prev_stall && (!s_valid || s_bin != p_bin || s_count != p_count || s_last != p_last))
                hold_err++;
            if (s_valid) begin
                if (s_last != (k == 255)) last_err++;
                if (hr) begin
                    if (s_bin != 8'(k)) order_err++;
                    got[k] = s_count;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                    if (s_count != e) bad++;
                    k++;
                end
            end
            prev_stall = s_valid && !hr;
            p_bin = s_bin;
            p_count = s_count;
            p_last = s_last;
            @(posedge clk);
            #1;
            if (cyc > 2000) timeout = 1'b1;
        end
        pv = 1'b0;
        hr = 1'b0;
        @(negedge clk);
        fd1 = o_frame_done;
        pr1 = o_pix_ready;
        @(posedge clk);
        #1;
        @(negedge clk);
        fd2 = o_frame_done;
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_timeout"},    32'(timeout), 32'd0);
        check({tag, "_ready_drop"}, 32'(first_ready), 32'd0);
        check({tag, "_latency"},    32'(lat > 0 && lat <= 4), 32'd1);
        check({tag, "_order"},      order_err, 32'd0);
        check({tag, "_last"},       last_err, 32'd0);
        check({tag, "_hold"},       hold_err, 32'd0);
        check({tag, "_done_early"}, fd_early, 32'd0);
        check({tag, "_bins"},       bad, 32'd0);
        check({tag, "_done_pulse"}, 32'(fd1), 32'd1);
        check({tag, "_ready_back"}, 32'(pr1), 32'd1);
        check({tag, "_done_once"},  32'(fd2), 32'd0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Directed test sequence
    initial begin
        int          n;
        int          cyc;
        logic        found;
        logic [7:0]  pat [8];
        logic [31:0] max24;
        n_checks = 0;
        n_errors = 0;
        sel = 2'd0; pv = 1'b0; pd = 8'd0; hr = 1'b0; rst_n = 1'b0;
        max24 = 32'h00FF_FFFF;
        pat = '{8'd5, 8'd5, 8'd5, 8'd7, 8'd5, 8'd7, 8'd7, 8'd7};
        for (int i = 0; i < 256; i++) exp_h[i] = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready",  32'(o_pix_ready), 32'd0);
        check("rst_hist_valid", 32'(o_hist_valid), 32'd0);
        check("rst_hist_bin",   32'(o_hist_bin), 32'd0);
        check("rst_hist_count", o_hist_count, 32'd0);
        check("rst_hist_last",  32'(o_hist_last), 32'd0);
        check("rst_frame_done", 32'(o_frame_done), 32'd0);
        rst_n = 1'b1;
        wait_clear(n);
        check("clear_len", n, 32'd256);
        @(posedge clk);
        #1;

        // All zero pixels; pixels offered during drain/readout must be ignored
        for (int i = 0; i < 16; i++) begin
            model_add(8'h00, max24);
            send_pixel(8'h00);
        end
        model_push();
        pv = 1'b1;
        pd = 8'h01;
        readout(1'b0);
        check_frame("zeros");
        check("zeros_bin0", got[0], 32'd16);
        check("zeros_bin255", got[255], 32'd0);

        // Back-to-back repeats exercising forwarding
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) begin
                model_add(pat[i], max24);
                send_pixel(pat[i]);
            end
        model_push();
        readout(1'b0);
        check_frame("fwd");
        check("fwd_bin5", got[5], 32'd8);
        check("fwd_bin7", got[7], 32'd8);
        check("fwd_bin1_ignored", got[1], 32'd0);

        // Two frames: clear-on-read
        for (int i = 0; i < 16; i++) begin
            model_add(8'h10, max24);
            send_pixel(8'h10);
        end
        model_push();
        readout(1'b0);
        check_frame("f10");
        check("f10_bin10", got[8'h10], 32'd16);
        for (int i = 0; i < 16; i++) begin
            model_add(8'h20, max24);
            send_pixel(8'h20);
        end
        model_push();
        readout(1'b0);
        check_frame("f20");
        check("f20_bin10", got[8'h10], 32'd0);
        check("f20_bin20", got[8'h20], 32'd16);

        // Ramp 0..255 with valid gaps and random ready
        sel = 2'd1;
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            model_add(8'(v), max24);
            send_pixel(8'(v));
        end
        model_push();
        readout(1'b1);
        check_frame("ramp");
        check("ramp_bin0", got[0], 32'd1);
        check("ramp_bin128", got[128], 32'd1);
        check("ramp_bin255", got[255], 32'd1);

        // Saturation with 4-bit bins
        sel = 2'd2;
        for (int i = 0; i < 20; i++) begin
            model_add(8'hFF, 32'd15);
            send_pixel(8'hFF);
        end
        model_push();
        readout(1'b0);
        check_frame("sat");
        check("sat_bin255", got[255], 32'd15);

        // Reset in the middle of readout
        sel = 2'd0;
        for (int i = 0; i < 16; i++) send_pixel(8'hC8);
        hr = 1'b1;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 600) begin
            @(negedge clk);
            if (o_hist_valid && o_hist_bin == 8'd100) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        check("mid_reach_bin100", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_hist_valid), 32'd0);
        check("mid_rst_count", o_hist_count, 32'd0);
        check("mid_rst_bin",   32'(o_hist_bin), 32'd0);
        hr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(n);
        check("mid_clear_len", n, 32'd256);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            model_add(8'h03, max24);
            send_pixel(8'h03);
        end
        model_push();
        readout(1'b0);
        check_frame("after_rst");
        check("after_rst_bin3", got[3], 32'd16);
        check("after_rst_binC8", got[8'hC8], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/histogram_hesaplama.md
# histogram_hesaplama

Streaming histogram builder: counts occurrences of each 8-bit pixel value over one frame of `PIXELS` pixels, then emits the 256 bin counts in order over a valid/ready stream. It sits upstream of the histogram-equalization stage and produces the histogram table that stage consumes, in bin order 0..255. It replaces the file-loaded histogram with a hardware-computed one.

## Interface
- `PIXELS`, 76800, pixels per frame (320x240); counter width is `$clog2(PIXELS+1)`.
- `BIN_W`, 24, width of each bin count.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pix_valid`  in  1  a pixel is offered on `pix_data`.
- `pix_ready`  out  1  block accepts the pixel this cycle.
- `pix_data`  in  8  pixel value (bin index).
- `hist_valid`  out  1  `hist_bin`/`hist_count` are valid.
- `hist_ready`  in  1  consumer accepts the current bin.
- `hist_bin`  out  8  bin index being output.
- `hist_count`  out  BIN_W  count for `hist_bin`.
- `hist_last`  out  1  high with bin 255.
- `frame_done`  out  1  one-cycle pulse after bin 255 handshake.

## Operation
- Memory: 256 x BIN_W array with synchronous (registered) read and one write port. It is not reset.
- States:
  - CLEAR: entered from reset. Writes 0 to bins 0..255, one per cycle (256 cycles), then goes to COLLECT.
  - COLLECT: `pix_ready`=1 while accepted-count < PIXELS. A pixel is accepted when `pix_valid && pix_ready`. When the PIXELS-th pixel is accepted, `pix_ready` drops the next cycle and the state goes to DRAIN.
  - DRAIN: waits until the increment pipeline is empty, then goes to READOUT.
  - READOUT: presents bins 0..255 in order. On each handshake the presented bin is written to 0 and the next bin is presented. After the bin-255 handshake, `frame_done` pulses, the pixel counter resets to 0, and the state returns to COLLECT; no CLEAR pass is needed.
- Increment pipeline (read-modify-write over 3 cycles):
  - Stage S1 registers the accepted bin and issues the memory read.
  - Stage S2 holds the bin and its count+1.
  - S2 writes memory the following cycle.
- Hazard forwarding is mandatory. If S1.bin == S2.bin with S2 valid, S2's next count is S2.count+1 and the stale memory data is ignored. Any in-flight write to the same bin must be forwarded likewise. Back-to-back identical pixels must yield exact counts.
- Arithmetic: increments saturate at 2^BIN_W-1. The pixel counter never wraps within a frame.
- Readout prefetch: the read of bin n+1 is issued on the handshake of bin n. Throughput is one bin per cycle with `hist_ready` held high.

## Timing
- Reset values: `pix_ready`=0, `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_last`=0, `frame_done`=0. State=CLEAR, all counters 0.
- Asserting `rst_n` low in any state aborts immediately:
  - the partial frame is discarded;
  - outputs take their reset values asynchronously;
  - after release, CLEAR runs again.
- First `pix_ready`=1 occurs on cycle 257 after reset release (256 CLEAR cycles).
- First `hist_valid`=1 occurs no more than 4 cycles after the final pixel acceptance.
- Hold rule: while `hist_valid`=1 and `hist_ready`=0, `hist_bin`, `hist_count` and `hist_last` hold stable. `hist_valid` never drops without a handshake.
- `frame_done` is high for exactly the cycle after the bin-255 handshake. `pix_ready` rises in that same cycle.
- In states other than COLLECT, `pix_valid` is ignored and no pixel is counted.

## Test plan
- `PIXELS`=16, all pixels 0x00, `hist_ready`=1 -> bin 0 reads 16, bins 1..255 read 0. `hist_last` is high only on bin 255. `frame_done` pulses once.
- `PIXELS`=16, stream 5,5,5,7,5,7,7,7 repeated twice with no gaps -> bin 5 = 8, bin 7 = 8, all other bins 0. This exercises forwarding.
- `PIXELS`=256, values 0..255 with random `pix_valid` gaps -> every bin = 1. With `hist_ready` toggled randomly, outputs hold stable while stalled, and the 256 bins arrive in order.
- Two consecutive frames, first all 0x10 and second all 0x20 (`PIXELS`=16) -> frame 2 reports bin 0x10 = 0 and bin 0x20 = 16. This confirms clear-on-read.
- `BIN_W`=4, `PIXELS`=20, all pixels 0xFF -> bin 255 reads 15 (saturated).
- `rst_n` pulsed low mid-READOUT at bin 100 -> `hist_valid` goes 0 immediately. After release, CLEAR runs 256 cycles, and a new all-0x03 frame reports only bin 3 = `PIXELS`.
